partial_product_accumulator: RTL and testbench

//  Sits directly downstream of Vector_Multiplier. Accumulates the 16-bit dot-product partial_product
//  of every neighbour of one graph node (GNN sum aggregation) into a wide register. At the end of the

---
 rtl/gnn_pkg.sv | 9 +
 rtl/partial_product_accumulator_if.sv | 24 ++
 rtl/partial_product_accumulator_shift_saturate.sv | 13 +
 rtl/partial_product_accumulator.sv | 62 ++++++
 tb/tb_partial_product_accumulator.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/gnn_pkg.sv
// gnn_pkg: shared GNN datapath widths, types and accumulator states
package gnn_pkg;
  localparam int PP_W = 16;
  localparam int FEAT_W = 5;
  localparam int VEC_LEN = 96;
  typedef logic [PP_W-1:0] pp_t;
  typedef logic [FEAT_W-1:0] feat_t;
  typedef enum logic {IDLE, ACCUM} acc_state_e;
endpackage

// File: rtl/partial_product_accumulator_if.sv
// partial_product_accumulator_if: partial-product input stream and node-result output stream
interface partial_product_accumulator_if import gnn_pkg::*; #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) ();
  logic pp_valid;
  logic pp_ready;
  pp_t pp_data;
  logic pp_last;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] out_acc;
  feat_t out_feature;
  logic [CNT_W-1:0] out_terms;
  logic out_overflow;
  modport slave (
    input pp_valid, pp_data, pp_last, out_ready,
    output pp_ready, out_valid, out_acc, out_feature, out_terms, out_overflow
  );
  modport master (
    output pp_valid, pp_data, pp_last, out_ready,
    input pp_ready, out_valid, out_acc, out_feature, out_terms, out_overflow
  );
endinterface

// File: rtl/partial_product_accumulator_shift_saturate.sv
// shift_saturate: right-shifts the node sum and clamps it to the feature width
module shift_saturate #(
  parameter int ACC_W = 24,
  parameter int SHIFT = 4,
  parameter int FEAT_W = 5
) (
  input  logic [ACC_W-1:0]  i_acc,
  output logic [FEAT_W-1:0] o_feature
);
  logic [ACC_W-1:0] w_sh;
  assign w_sh = i_acc >> SHIFT;
  assign o_feature = |w_sh[ACC_W-1:FEAT_W] ? '1 : w_sh[FEAT_W-1:0];
endmodule

// File: rtl/partial_product_accumulator.sv
// partial_product_accumulator: sums one node's neighbour partial products, emits raw and re-quantised result
module partial_product_accumulator import gnn_pkg::*; #(
  parameter int ACC_W = 24,
  parameter int SHIFT = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  partial_product_accumulator_if.slave bus
);
  acc_state_e r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic r_ovf;
  logic w_fire, w_idle, w_ovf;
  logic [ACC_W:0] w_sum;
  logic [ACC_W-1:0] w_acc;
  logic [CNT_W-1:0] w_cnt_base, w_cnt;
  feat_t w_feat;
  assign bus.pp_ready = !bus.out_valid | bus.out_ready;
  assign w_fire = bus.pp_valid & bus.pp_ready;
  assign w_idle = r_state == IDLE;
  // IDLE means the accumulator is logically empty, so the first beat starts from zero
  assign w_sum = {1'b0, w_idle ? {ACC_W{1'b0}} : r_acc} + (ACC_W+1)'(bus.pp_data);
  assign w_acc = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
  assign w_ovf = w_sum[ACC_W] | (!w_idle & r_ovf);
  assign w_cnt_base = w_idle ? '0 : r_cnt;
  assign w_cnt = &w_cnt_base ? w_cnt_base : w_cnt_base + CNT_W'(1);
  shift_saturate #(.ACC_W(ACC_W), .SHIFT(SHIFT), .FEAT_W(FEAT_W)) u_sat (
    .i_acc(w_acc),
    .o_feature(w_feat)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_acc <= '0;
      bus.out_feature <= '0;
      bus.out_terms <= '0;
      bus.out_overflow <= 1'b0;
    end else begin
      if (w_fire) begin
        r_state <= bus.pp_last ? IDLE : ACCUM;
        r_acc <= bus.pp_last ? '0 : w_acc;
        r_cnt <= bus.pp_last ? '0 : w_cnt;
        r_ovf <= bus.pp_last ? 1'b0 : w_ovf;
      end
      if (w_fire & bus.pp_last) begin
        bus.out_valid <= 1'b1;
        bus.out_acc <= w_acc;
        bus.out_feature <= w_feat;
        bus.out_terms <= w_cnt;
        bus.out_overflow <= w_ovf;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_partial_product_accumulator.sv
// tb_partial_product_accumulator: directed stimulus with a result scoreboard
module tb_partial_product_accumulator;
  import gnn_pkg::*;
  typedef struct packed {
    logic [23:0] acc;
    feat_t feat;
    logic [7:0] terms;
    logic ovf;
  } res_t;
  localparam longint ACC_MAX = 64'd16777215;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pop_cyc[$];
  res_t q[$];
  longint m_sum = 0;
  int m_cnt = 0;
  int w;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  partial_product_accumulator_if bus ();
  partial_product_accumulator dut (.clk(clk), .reset(reset), .bus(bus));

  always @(negedge clk) begin
    res_t got, exp;
    if (!reset && bus.out_valid && bus.out_ready) begin
      got = {bus.out_acc, bus.out_feature, bus.out_terms, bus.out_overflow};
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $error("FAIL result: unexpected acc=%0d terms=%0d", got.acc, got.terms);
      end else begin
        exp = q.pop_front();
        assert (got === exp) else begin
          n_bad++;
          $error("FAIL result: got acc=%0d feat=%0d terms=%0d ovf=%0d, want acc=%0d feat=%0d terms=%0d ovf=%0d",
                 got.acc, got.feat, got.terms, got.ovf, exp.acc, exp.feat, exp.terms, exp.ovf);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic beat(input int d, input bit last, output int waits);
    res_t e;
    longint a;
    bit ok;
    bus.pp_valid = 1'b1;
    bus.pp_data = 16'(d);
    bus.pp_last = last;
    waits = 0;
    ok = 1'b0;
    while (!ok && waits <= 50) begin
      @(negedge clk);
      if (bus.pp_ready) ok = 1'b1;
      else waits++;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $error("FAIL beat_timeout: got no pp_ready want pp_ready=1");
    end
    @(posedge clk);
    #1;
    bus.pp_valid = 1'b0;
    if (ok) begin
      m_sum += longint'(d);
      m_cnt++;
      if (last) begin
        a = (m_sum > ACC_MAX) ? ACC_MAX : m_sum;
        e.acc = 24'(a);
        e.feat = ((a >> 4) > 31) ? 5'd31 : 5'(a >> 4);
        e.terms = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
        e.ovf = m_sum > ACC_MAX;
        q.push_back(e);
        m_sum = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_acc"}, 32'(bus.out_acc), 0);
    chk({tag, "_feat"}, 32'(bus.out_feature), 0);
    chk({tag, "_terms"}, 32'(bus.out_terms), 0);
    chk({tag, "_ovf"}, 32'(bus.out_overflow), 0);
  endtask

  initial begin
    bus.pp_valid = 1'b0;
    bus.pp_data = '0;
    bus.pp_last = 1'b0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    idle(2);
    chk_zero("reset");
    chk("reset_ready", 32'(bus.pp_ready), 1);
    reset = 1'b0;
    idle(1);
    beat(40, 0, w);
    beat(60, 0, w);
    beat(100, 1, w);
    chk("t1_latency", 32'(bus.out_valid), 1);
    idle(3);
    chk("t1_valid_drop", 32'(bus.out_valid), 0);
    chk("t1_acc_hold", 32'(bus.out_acc), 200);
    beat(1000, 0, w);
    beat(1000, 1, w);
    idle(3);
    for (int i = 0; i < 257; i++) beat(65535, i == 256, w);
    idle(3);
    bus.out_ready = 1'b0;
    beat(100, 0, w);
    beat(150, 1, w);
    bus.pp_valid = 1'b1;
    bus.pp_data = 16'd11;
    bus.pp_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_ready", 32'(bus.pp_ready), 0);
      chk("t4_valid", 32'(bus.out_valid), 1);
      chk("t4_acc", 32'(bus.out_acc), 250);
      chk("t4_feat", 32'(bus.out_feature), 15);
      chk("t4_terms", 32'(bus.out_terms), 2);
    end
    @(posedge clk);
    #1;
    bus.pp_valid = 1'b0;
    bus.out_ready = 1'b1;
    beat(2, 0, w);
    beat(3, 1, w);
    idle(3);
    pop_cyc.delete();
    beat(7, 1, w);
    chk("t5_wait7", 32'(w), 0);
    beat(8, 1, w);
    chk("t5_wait8", 32'(w), 0);
    beat(9, 1, w);
    chk("t5_wait9", 32'(w), 0);
    idle(3);
    chk("t5_pops", 32'(pop_cyc.size()), 3);
    if (pop_cyc.size() == 3) begin
      chk("t5_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 1);
      chk("t5_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 1);
    end
    beat(50, 0, w);
    beat(50, 0, w);
    reset = 1'b1;
    #1;
    chk_zero("t6_reset");
    m_sum = 0;
    m_cnt = 0;
    idle(2);
    chk_zero("t6_held");
    reset = 1'b0;
    idle(1);
    beat(5, 1, w);
    idle(3);
    chk("queue_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
